// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, issues one 8-byte-aligned request at a
// time, and presents up to two instructions per beat to decode.
module fetch_ctrl #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [63:0]     imem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out1_pc,
  output logic [31:0]     out1_inst,
  output logic            out2_valid,
  output logic [PC_W-1:0] out2_pc,
  output logic [31:0]     out2_inst,
  input  logic            pred_flag,
  input  logic [PC_W-1:0] pred_addr,
  input  logic            branch_flag,
  input  logic [PC_W-1:0] branch_addr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] fpc_q;
  logic            drop_q;
  logic [PC_W-1:0] out1_pc_q, out2_pc_q;
  logic [31:0]     out1_inst_q, out2_inst_q;
  logic            out2_valid_q;

  logic [PC_W-1:0] branch_pc, pred_pc, seq_pc;

  // Redirect targets are word aligned; low two address bits are discarded.
  assign branch_pc = branch_addr & ~PC_W'(3);
  assign pred_pc   = pred_addr & ~PC_W'(3);
  assign seq_pc    = {fpc_q[PC_W-1:3], 3'b000} + PC_W'(8);

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = {pc_q[PC_W-1:3], 3'b000};
  assign out_valid      = (state_q == HOLD);
  assign out1_pc        = out1_pc_q;
  assign out1_inst      = out1_inst_q;
  assign out2_valid     = out2_valid_q;
  assign out2_pc        = out2_pc_q;
  assign out2_inst      = out2_inst_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      fpc_q        <= '0;
      drop_q       <= 1'b0;
      out1_pc_q    <= '0;
      out2_pc_q    <= '0;
      out1_inst_q  <= NOP_INST;
      out2_inst_q  <= NOP_INST;
      out2_valid_q <= 1'b0;
    end else if (branch_flag) begin
      pc_q <= branch_pc;
      case (state_q)
        REQ: begin
          // The handshake still completes; its response must be squashed.
          if (imem_req_ready) begin
            fpc_q   <= pc_q;
            drop_q  <= 1'b1;
            state_q <= WAIT;
          end else begin
            state_q <= REQ;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            drop_q  <= 1'b0;
            state_q <= REQ;
          end else begin
            drop_q  <= 1'b1;
          end
        end
        default: state_q <= REQ;
      endcase
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (imem_req_ready) begin
            fpc_q   <= pc_q;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= REQ;
            end else begin
              out1_pc_q <= fpc_q;
              out2_pc_q <= fpc_q + PC_W'(4);
              if (!fpc_q[2]) begin
                out1_inst_q  <= imem_resp_data[31:0];
                out2_inst_q  <= imem_resp_data[63:32];
                out2_valid_q <= 1'b1;
              end else begin
                out1_inst_q  <= imem_resp_data[63:32];
                out2_valid_q <= 1'b0;
              end
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            pc_q    <= pred_flag ? pred_pc : seq_pc;
            state_q <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a transaction-level model of the fetch pipeline plus a
// randomised instruction memory, with directed redirect/wrap/reset scenarios.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [63:0] imem_resp_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out1_pc, out1_inst, out2_pc, out2_inst;
  logic        out2_valid;
  logic        pred_flag = 1'b0, branch_flag = 1'b0;
  logic [31:0] pred_addr = '0, branch_addr = '0;

  fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out1_pc(out1_pc), .out1_inst(out1_inst),
    .out2_valid(out2_valid), .out2_pc(out2_pc), .out2_inst(out2_inst),
    .pred_flag(pred_flag), .pred_addr(pred_addr),
    .branch_flag(branch_flag), .branch_addr(branch_addr)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Stimulus knobs used by step()
  logic        d_rdy = 1'b1, d_ordy = 1'b1, d_pf = 1'b0, d_br = 1'b0, spur_en = 1'b0;
  logic [31:0] d_pa = '0, d_bra = '0;
  int          lat_min = 0, lat_max = 0;

  // Memory model
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;

  // Transaction-level reference model
  logic        m_idle, m_wait, m_dead, m_hold;
  logic [31:0] m_pc, m_fpc, m_hpc;

  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic exp_req();
    return !m_idle && !m_wait && !m_hold;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_wait = 1'b0; m_dead = 1'b0; m_hold = 1'b0;
    m_pc = RESET_PC; m_fpc = '0; m_hpc = '0;
    mem_busy = 1'b0;
  endtask

  task automatic check_all();
    chk("req_valid", imem_req_valid, exp_req());
    if (exp_req()) chk("req_addr", imem_req_addr, {m_pc[31:3], 3'b000});
    chk("out_valid", out_valid, m_hold);
    if (m_hold) begin
      chk("out1_pc", out1_pc, m_hpc);
      chk("out1_inst", out1_inst, memword(m_hpc));
      chk("out2_valid", out2_valid, !m_hpc[2]);
      if (!m_hpc[2]) begin
        chk("out2_pc", out2_pc, m_hpc + 32'd4);
        chk("out2_inst", out2_inst, memword(m_hpc + 32'd4));
      end
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_valid"}, imem_req_valid, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out2_valid"}, out2_valid, 1'b0);
    chk({tag, "_out1_pc"}, out1_pc, 32'h0);
    chk({tag, "_out2_pc"}, out2_pc, 32'h0);
    chk({tag, "_out1_inst"}, out1_inst, NOP_INST);
    chk({tag, "_out2_inst"}, out2_inst, NOP_INST);
  endtask

  // One clock: drive inputs, advance model at the edge, check at the falling edge.
  task automatic step();
    logic        rv, req_seen, o_req, o_wait, o_dead, o_hold;
    logic [31:0] req_addr_seen, o_pc;
    logic [63:0] rdata;
    rv = 1'b0;
    rdata = {$urandom, $urandom};
    if (mem_busy && mem_cnt == 0) begin
      rv = 1'b1;
      rdata = {memword(mem_addr + 32'd4), memword(mem_addr)};
    end else if (!mem_busy && spur_en && $urandom_range(0, 3) == 0) begin
      rv = 1'b1;
    end
    imem_resp_valid = rv;  imem_resp_data = rdata;
    imem_req_ready = d_rdy; out_ready = d_ordy;
    pred_flag = d_pf;       pred_addr = d_pa;
    branch_flag = d_br;     branch_addr = d_bra;
    req_seen = imem_req_valid; req_addr_seen = imem_req_addr;
    o_req = exp_req(); o_wait = m_wait; o_dead = m_dead; o_hold = m_hold; o_pc = m_pc;
    @(posedge clk);
    if (mem_busy) begin
      if (mem_cnt == 0) mem_busy = 1'b0;
      else mem_cnt--;
    end
    if (req_seen && d_rdy) begin
      mem_busy = 1'b1; mem_addr = req_addr_seen;
      mem_cnt = $urandom_range(lat_min, lat_max);
    end
    m_idle = 1'b0;
    if (o_req && d_rdy) begin
      m_wait = 1'b1; m_fpc = o_pc; m_dead = d_br;
    end
    if (o_wait && rv) begin
      m_wait = 1'b0; m_dead = 1'b0;
      if (!o_dead && !d_br) begin m_hold = 1'b1; m_hpc = m_fpc; end
    end else if (o_wait && d_br) begin
      m_dead = 1'b1;
    end
    if (o_hold) begin
      if (d_br) m_hold = 1'b0;
      else if (d_ordy) begin
        m_hold = 1'b0;
        m_pc = d_pf ? (d_pa & ~32'd3) : ((m_hpc & ~32'd7) + 32'd8);
      end
    end
    if (d_br) m_pc = d_bra & ~32'd3;
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until_hold();
    int n = 0;
    while (!m_hold && n < 40) begin step(); n++; end
    chk("hold_reached", out_valid, 1'b1);
  endtask

  task automatic run_until_wait();
    int n = 0;
    while (!m_wait && n < 40) begin step(); n++; end
    chk("wait_reached", imem_req_valid, 1'b0);
  endtask

  task automatic run_until_req();
    int n = 0;
    while (!imem_req_valid && n < 40) begin step(); n++; end
    chk("req_reached", imem_req_valid, 1'b1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    check_all();

    // 1. back-to-back sequential fetch with a 1-cycle memory
    for (int i = 0; i < 20; i++) step();

    // 2. branch to an odd-word target taken in HOLD
    run_until_hold();
    d_br = 1'b1; d_bra = 32'h8000_0104; step(); d_br = 1'b0;
    chk("br_addr", imem_req_addr, 32'h8000_0100);
    run_until_hold();
    chk("br_out1_pc", out1_pc, 32'h8000_0104);
    chk("br_out2_valid", out2_valid, 1'b0);

    // 3. branch while waiting, response arrives later and is squashed
    lat_min = 3; lat_max = 3;
    run_until_wait();
    d_br = 1'b1; d_bra = 32'h8000_0502; step(); d_br = 1'b0;
    run_until_req();
    chk("drop_addr", imem_req_addr, 32'h8000_0500);
    lat_min = 0; lat_max = 2;

    // 4. decode stall then predicted redirect
    run_until_hold();
    d_ordy = 1'b0;
    for (int i = 0; i < 5; i++) step();
    d_ordy = 1'b1; d_pf = 1'b1; d_pa = 32'h8000_0201; step(); d_pf = 1'b0;
    chk("pred_addr", imem_req_addr, 32'h8000_0200);

    // 5. branch, accept and prediction in the same HOLD cycle
    run_until_hold();
    d_br = 1'b1; d_bra = 32'h8000_0300; d_pf = 1'b1; d_pa = 32'h8000_0400;
    step();
    d_br = 1'b0; d_pf = 1'b0;
    chk("br_wins", imem_req_addr, 32'h8000_0300);

    // 6. address wrap, then reset in the middle of a wait
    run_until_hold();
    d_br = 1'b1; d_bra = 32'hFFFF_FFF8; step(); d_br = 1'b0;
    run_until_hold();
    step();
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);
    lat_min = 3; lat_max = 3;
    run_until_wait();
    imem_resp_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all();
    step();
    chk("rst_first_addr", imem_req_addr, RESET_PC);

    // Random traffic against the model
    spur_en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      lat_min = 0; lat_max = 3;
      d_rdy  = ($urandom_range(0, 3) != 0);
      d_ordy = ($urandom_range(0, 2) != 0);
      d_pf   = ($urandom_range(0, 3) == 0);
      d_pa   = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      d_br   = ($urandom_range(0, 9) == 0);
      d_bra  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                           : (32'h8000_0000 | ($urandom & 32'h0000_0FFF));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
